// File: rtl/elevator_request_scheduler.sv
// Upstream request scheduler: latches car/hall calls, runs a SCAN direction FSM
// and presents one registered target floor to the elevator controller.
module elevator_request_scheduler #(
  parameter int         NFLOOR     = 4,
  parameter logic [1:0] FIRE_FLOOR = 2'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       BG,
  input  logic       BF1,
  input  logic       BF2,
  input  logic       BF3,
  input  logic       reqG,
  input  logic       reqF1,
  input  logic       reqF2,
  input  logic       reqF3,
  input  logic [1:0] prox,
  input  logic       door_open,
  input  logic       overload,
  input  logic       firealarm,
  output logic [1:0] target,
  output logic       target_valid,
  output logic       dir_up,
  output logic       dir_down,
  output logic       fire_mode,
  output logic [3:0] pending
);

  typedef enum logic [1:0] {S_IDLE, S_UP, S_DOWN, S_FIRE} state_e;

  state_e     state_q, state_d;
  logic [3:0] pending_q, pending_d;
  logic [3:0] req, serve;
  logic [1:0] target_q, target_d;
  logic       valid_q, valid_d;
  logic       dir_up_q, dir_down_q, fire_q;

  logic       here, above, below, up_hit, dn_hit, go_up;
  logic [1:0] up_tgt, dn_tgt, abv_tgt, blw_tgt, dist_up, dist_dn;

  assign req = {BF3 | reqF3, BF2 | reqF2, BF1 | reqF1, BG | reqG};

  always_comb begin
    serve = '0;
    if (door_open) serve[prox] = 1'b1;
    pending_d = (pending_q | req) & ~serve;
    // Fire recall drops every call, including the ones pressed during it.
    if (firealarm || state_q == S_FIRE) pending_d = '0;
  end

  // Scan the pending bitmap relative to the current car floor.
  always_comb begin
    up_hit  = 1'b0;
    dn_hit  = 1'b0;
    above   = 1'b0;
    below   = 1'b0;
    up_tgt  = prox;
    dn_tgt  = prox;
    abv_tgt = prox;
    blw_tgt = prox;
    for (int i = NFLOOR - 1; i >= 0; i--) begin
      if (pending_q[i] && i >= int'(prox)) begin
        up_hit = 1'b1;
        up_tgt = 2'(i);
      end
      if (pending_q[i] && i > int'(prox)) begin
        above   = 1'b1;
        abv_tgt = 2'(i);
      end
    end
    for (int i = 0; i < NFLOOR; i++) begin
      if (pending_q[i] && i <= int'(prox)) begin
        dn_hit = 1'b1;
        dn_tgt = 2'(i);
      end
      if (pending_q[i] && i < int'(prox)) begin
        below   = 1'b1;
        blw_tgt = 2'(i);
      end
    end
    here    = pending_q[prox];
    dist_up = abv_tgt - prox;
    dist_dn = prox - blw_tgt;
    go_up   = above && (!below || dist_up <= dist_dn);
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    valid_d  = 1'b0;
    if (firealarm) begin
      state_d  = S_FIRE;
      target_d = FIRE_FLOOR;
      valid_d  = 1'b1;
    end else if (overload) begin
      state_d = state_q;
    end else begin
      unique case (state_q)
        S_FIRE: state_d = S_IDLE;
        S_IDLE: begin
          if (here) begin
            target_d = prox;
            valid_d  = 1'b1;
          end else if (go_up) begin
            state_d  = S_UP;
            target_d = abv_tgt;
            valid_d  = 1'b1;
          end else if (below) begin
            state_d  = S_DOWN;
            target_d = blw_tgt;
            valid_d  = 1'b1;
          end
        end
        S_UP: begin
          if (up_hit) begin
            target_d = up_tgt;
            valid_d  = 1'b1;
          end else if (below) begin
            state_d  = S_DOWN;
            target_d = dn_tgt;
            valid_d  = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_DOWN: begin
          if (dn_hit) begin
            target_d = dn_tgt;
            valid_d  = 1'b1;
          end else if (above) begin
            state_d  = S_UP;
            target_d = up_tgt;
            valid_d  = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pending_q  <= '0;
      target_q   <= '0;
      valid_q    <= 1'b0;
      dir_up_q   <= 1'b0;
      dir_down_q <= 1'b0;
      fire_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      target_q   <= target_d;
      valid_q    <= valid_d;
      dir_up_q   <= (state_d == S_UP);
      dir_down_q <= (state_d == S_DOWN);
      fire_q     <= (state_d == S_FIRE);
    end
  end

  assign pending      = pending_q;
  assign target       = target_q;
  assign target_valid = valid_q;
  assign dir_up       = dir_up_q;
  assign dir_down     = dir_down_q;
  assign fire_mode    = fire_q;

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Directed bench for elevator_request_scheduler with a cycle-level reference
// model of the request/SCAN rules and hand-computed checkpoints.
module tb_elevator_request_scheduler;

  localparam int M_IDLE = 0, M_UP = 1, M_DOWN = 2, M_FIRE = 3;
  localparam int FIRE_FL = 0;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       BG = 0, BF1 = 0, BF2 = 0, BF3 = 0;
  logic       reqG = 0, reqF1 = 0, reqF2 = 0, reqF3 = 0;
  logic [1:0] prox = 2'd0;
  logic       door_open = 0, overload = 0, firealarm = 0;
  logic [1:0] target;
  logic       target_valid, dir_up, dir_down, fire_mode;
  logic [3:0] pending;

  int errors = 0;
  int checks = 0;
  bit started = 0;

  bit [3:0] m_pend = '0;
  int       m_mode = M_IDLE;
  int       m_tgt  = 0;
  bit       m_vld  = 0;

  elevator_request_scheduler #(.NFLOOR(4), .FIRE_FLOOR(2'd0)) dut (
    .clk(clk), .reset(reset),
    .BG(BG), .BF1(BF1), .BF2(BF2), .BF3(BF3),
    .reqG(reqG), .reqF1(reqF1), .reqF2(reqF2), .reqF3(reqF3),
    .prox(prox), .door_open(door_open), .overload(overload), .firealarm(firealarm),
    .target(target), .target_valid(target_valid), .dir_up(dir_up),
    .dir_down(dir_down), .fire_mode(fire_mode), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: next pending set and next scheduling decision per edge.
  always @(posedge clk) begin
    bit [3:0] rq, np;
    int p, nm, nt, up_t, dn_t;
    bit nv;
    rq = {BF3 | reqF3, BF2 | reqF2, BF1 | reqF1, BG | reqG};
    p  = int'(prox);
    if (reset) begin
      m_pend = '0; m_mode = M_IDLE; m_tgt = 0; m_vld = 0;
    end else begin
      np = m_pend | rq;
      if (door_open) np[p] = 1'b0;
      if (firealarm || m_mode == M_FIRE) np = '0;
      up_t = -1;
      for (int f = p; f <= 3; f++) if (m_pend[f]) begin up_t = f; break; end
      dn_t = -1;
      for (int f = p; f >= 0; f--) if (m_pend[f]) begin dn_t = f; break; end
      nm = m_mode; nt = m_tgt; nv = 0;
      if (firealarm) begin
        nm = M_FIRE; nt = FIRE_FL; nv = 1;
      end else if (overload) begin
        nm = m_mode;
      end else if (m_mode == M_FIRE) begin
        nm = M_IDLE;
      end else if (m_mode == M_IDLE) begin
        if (m_pend[p]) begin
          nt = p; nv = 1;
        end else begin
          for (int d = 1; d <= 3; d++) begin
            if (p + d <= 3 && m_pend[p + d]) begin nm = M_UP; nt = p + d; nv = 1; break; end
            if (p - d >= 0 && m_pend[p - d]) begin nm = M_DOWN; nt = p - d; nv = 1; break; end
          end
        end
      end else if (m_mode == M_UP) begin
        if (up_t >= 0) begin nt = up_t; nv = 1; end
        else if (dn_t >= 0) begin nm = M_DOWN; nt = dn_t; nv = 1; end
        else nm = M_IDLE;
      end else begin
        if (dn_t >= 0) begin nt = dn_t; nv = 1; end
        else if (up_t >= 0) begin nm = M_UP; nt = up_t; nv = 1; end
        else nm = M_IDLE;
      end
      m_pend = np; m_mode = nm; m_tgt = nt; m_vld = nv;
    end
  end

  always @(posedge clk) begin
    #2;
    if (started) begin
      chk("pending", pending, m_pend);
      chk("target_valid", target_valid, m_vld);
      chk("dir_up", dir_up, m_mode == M_UP);
      chk("dir_down", dir_down, m_mode == M_DOWN);
      chk("fire_mode", fire_mode, m_mode == M_FIRE);
      if (m_vld) chk("target", target, m_tgt);
    end
  end

  initial begin
    reset = 1;
    tick(2);
    started = 1;
    chk("rst_pending", pending, 0);
    chk("rst_valid", target_valid, 0);
    chk("rst_target", target, 0);
    chk("rst_dirs", {dir_up, dir_down, fire_mode}, 0);
    reset = 0;

    // Single car call above the car.
    prox = 0; BF2 = 1; tick();
    BF2 = 0;
    chk("t1_pending", pending, 4'b0100);
    chk("t1_valid_lat", target_valid, 0);
    tick();
    chk("t1_target", target, 2);
    chk("t1_valid", target_valid, 1);
    chk("t1_dir_up", dir_up, 1);
    prox = 2; door_open = 1; tick();
    chk("t1_served", pending, 0);
    door_open = 0; tick();
    chk("t1_idle_valid", target_valid, 0);
    chk("t1_idle_dir", {dir_up, dir_down}, 0);

    // Going up from floor 1, intermediate hall call is taken first.
    prox = 1; BF3 = 1; tick();
    BF3 = 0; tick();
    chk("t2_up", dir_up, 1);
    BG = 1; tick();
    BG = 0; tick();
    chk("t2_pending", pending, 4'b1001);
    reqF2 = 1; tick();
    reqF2 = 0; tick();
    chk("t2_target_f2", target, 2);
    prox = 2; door_open = 1; tick();
    prox = 3; tick();
    door_open = 0; tick();
    chk("t2_dir_down", dir_down, 1);
    chk("t2_target_g", target, 0);
    chk("t2_valid", target_valid, 1);

    // Reset while travelling down discards requests.
    BF1 = 1; tick();
    BF1 = 0;
    chk("t6_pending", pending, 4'b0011);
    chk("t6_down", dir_down, 1);
    reset = 1; tick();
    chk("t6_rst_pending", pending, 0);
    chk("t6_rst_outs", {target, target_valid, dir_up, dir_down, fire_mode}, 0);
    reset = 0;

    // Overload: latching continues, FSM frozen, valid suppressed.
    prox = 2; overload = 1; reqG = 1; tick();
    reqG = 0; tick();
    chk("t3_pending", pending, 4'b0001);
    chk("t3_valid", target_valid, 0);
    chk("t3_frozen", {dir_up, dir_down}, 0);
    overload = 0; tick();
    chk("t3_down", dir_down, 1);
    chk("t3_target", target, 0);
    chk("t3_valid_on", target_valid, 1);

    // Fire recall clears requests and blocks new ones.
    prox = 0; door_open = 1; tick();
    door_open = 0; tick();
    BF1 = 1; BF3 = 1; tick();
    BF3 = 0;
    chk("t4_pending", pending, 4'b1010);
    firealarm = 1; tick();
    chk("t4_cleared", pending, 0);
    chk("t4_fire", fire_mode, 1);
    chk("t4_target", target, FIRE_FL);
    chk("t4_valid", target_valid, 1);
    BF1 = 0; BF2 = 1; tick();
    chk("t4_lost", pending, 0);
    firealarm = 0; BF2 = 0; tick();
    chk("t4_exit_fire", fire_mode, 0);
    chk("t4_exit_pending", pending, 0);
    chk("t4_exit_valid", target_valid, 0);

    // Serve wins over a held button at the current floor.
    prox = 3; door_open = 1; BF3 = 1; tick();
    chk("t5_held0", pending[3], 0);
    tick();
    chk("t5_held1", pending[3], 0);
    door_open = 0; tick();
    chk("t5_latched", pending[3], 1);
    BF3 = 0; tick();
    chk("t5_here_tgt", target, 3);
    chk("t5_here_valid", target_valid, 1);
    door_open = 1; tick();
    door_open = 0; tick();

    // All four calls from floor 1: here first, then tie resolves upward.
    prox = 1; BG = 1; BF1 = 1; BF2 = 1; BF3 = 1; tick();
    BG = 0; BF1 = 0; BF2 = 0; BF3 = 0;
    chk("t7_all", pending, 4'b1111);
    tick();
    chk("t7_here", target, 1);
    chk("t7_idle", {dir_up, dir_down}, 0);
    door_open = 1; tick();
    door_open = 0; tick();
    chk("t7_tie_up", dir_up, 1);
    chk("t7_tie_tgt", target, 2);

    // DOWN at floor 0 with only an upper call turns around.
    prox = 2; door_open = 1; tick();
    prox = 3; tick();
    door_open = 0; tick();
    chk("t8_down", dir_down, 1);
    prox = 0; door_open = 1; BF2 = 1; tick();
    door_open = 0; BF2 = 0; tick();
    chk("t8_up", dir_up, 1);
    chk("t8_tgt", target, 2);
    tick(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
